uart_tx: RTL
============

# uart_tx

Serial UART transmitter: the stage that drives the serial line consumed by the team's UART receiver. It accepts bytes from on-chip logic through a single-cycle strobe, buffers up to `FIFO_DEPTH` bytes, and serialises each as an LSB-first frame (start bit, 8 data bits, stop bit) at a fixed baud rate derived from the system clock. Its `tx_pin` connects directly to the receiver's `rx_pin` for loopback, or to the board pin.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `BAUD_CNT_MAX`, `CLK_FREQ/BAUD` (5208): clocks per bit, integer division.
- `FIFO_DEPTH`, 4: byte buffer depth; power of two, ≥2.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pi_data` input 8: byte to send; sampled only when `pi_flag`=1.
- `pi_flag` input 1: one-cycle write strobe.
- `tx_pin` output 1: serial line; idle high.
- `tx_busy` output 1: high while a frame is on the line.
- `fifo_full` output 1: high when the buffer holds `FIFO_DEPTH` bytes.

## Operation
- FIFO: circular buffer with read/write pointers one bit wider than `log2(FIFO_DEPTH)`. Full when the MSBs differ and the rest match. Empty when the pointers are equal. Pointers wrap naturally.
- Write: on an edge with `pi_flag`=1 and `fifo_full`=0, `pi_data` is stored and the write pointer increments.
- A write while `fifo_full`=1 is dropped silently, even if a pop happens on the same edge.
- FSM states:
  - IDLE: `tx_pin`=1, `tx_busy`=0. If the FIFO is non-empty: pop the head into the shift register, set `tx_pin`=0, `tx_busy`=1, go to START.
  - START: hold low for `BAUD_CNT_MAX` clocks, then go to DATA with `tx_pin`=bit0.
  - DATA: the bit counter 0..7 selects the shift-register bit, LSB first. Each bit is held `BAUD_CNT_MAX` clocks. After bit7 go to STOP.
  - STOP: `tx_pin`=1 for `BAUD_CNT_MAX` clocks. At the end:
    - If the FIFO is non-empty: pop, go to START with `tx_pin`=0, `tx_busy` stays 1 (no idle gap).
    - Otherwise go to IDLE with `tx_busy`=0.
- Baud counter: counts 0..`BAUD_CNT_MAX`-1 and wraps. It is cleared on every state transition. Width is `$clog2(BAUD_CNT_MAX)`.
- `tx_pin` is registered; there are no combinational paths from inputs to outputs.
- A simultaneous write and pop with the FIFO neither full nor empty are both performed; occupancy is unchanged.
- A write to an empty FIFO on the edge where the FSM is in IDLE is popped on the following edge.

## Timing
- Reset values: `tx_pin`=1, `tx_busy`=0, `fifo_full`=0. FIFO is emptied, FSM is IDLE, all counters are 0.
- Reset asserted mid-frame: `tx_pin` returns to 1 asynchronously and all buffered bytes are discarded.
- Latency: `pi_flag` sampled at edge E, with FSM in IDLE and FIFO empty, makes `tx_pin` fall at edge E+1.
- Each bit lasts exactly `BAUD_CNT_MAX` clocks (104 160 ns at the defaults).
- One frame is 10×`BAUD_CNT_MAX` = 52 080 clocks.
- `fifo_full` updates on the same edge as the write or pop that changes occupancy.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state sits between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for `BAUD_CNT_MAX` clocks. The frame becomes 11 bits (57 288 clocks at the defaults).
- Macro undefined: no PARITY state and a 10-bit 8N1 frame.
- The receiver must be built with the matching framing.

## Test plan
- Reset, then idle for 1000 clocks -> `tx_pin`=1, `tx_busy`=0 and `fifo_full`=0 throughout.
- Single write 8'h55 -> `tx_pin` falls 1 clock after the strobe. Then 5208 clocks of 0, followed by bits 1,0,1,0,1,0,1,0 at 5208 clocks each, then 5208 clocks of 1. `tx_busy` drops after exactly 52 080 clocks.
- Back-to-back writes 8'h00..8'h03 on consecutive cycles -> four contiguous frames with no idle gap. `fifo_full` is never asserted, because the first byte is popped on the next edge.
- Six consecutive writes 8'h10..8'h15 -> `fifo_full`=1 after the fifth write, and 8'h15 is dropped. The line carries 8'h10..8'h14 in order, and `fifo_full` clears at the start of the second frame.
- Loopback into the receiver with bytes 8'h00..8'h07 -> the receiver pulses `po_flag` once per byte and `po_data` equals 0..7 in order.
- `rst_n` pulsed low for 3 clocks during DATA bit 3, with two bytes buffered -> `tx_pin`=1 immediately and no further frames. A subsequent write of 8'hA5 produces one clean frame.
- With `UART_TX_PARITY_EN`, write 8'h07 -> the parity bit is 1 and the frame lasts 57 288 clocks.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : FIFO-buffered UART transmitter, LSB-first 8N1 frames.
//             Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx_pin,
    output logic       tx_busy,
    output logic       fifo_full
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_ADDR_W:0]   c_PTR_ONE  = (c_ADDR_W + 1)'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Byte buffer
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W:0]   r_wr_ptr;
    logic [c_ADDR_W:0]   r_rd_ptr;
    logic                w_empty;
    logic                w_full;
    logic                w_wr;
    logic                w_pop;
    logic [7:0]          w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    // A write on a full buffer is dropped even if a pop frees a slot this edge.
    assign w_wr    = pi_flag && !w_full;
    assign w_head  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= pi_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_tx_pin;
    logic                w_tx_nxt;
    logic                r_tx_busy;
    logic                w_busy_nxt;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          r_shift;
    logic [c_CNT_W-1:0]  r_baud_cnt;
    logic                w_bit_end;
    logic                w_cnt_clr;

    assign w_bit_end = (r_baud_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx_pin;
        w_busy_nxt  = r_tx_busy;
        w_bit_nxt   = r_bit_idx;
        w_pop       = 1'b0;
        w_cnt_clr   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_cnt_clr   = 1'b1;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_clr = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = ^r_shift;
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt  = r_shift[w_bit_nxt];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_clr   = 1'b1;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_clr = 1'b1;
                    // Chain straight into the next frame when a byte is waiting.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_pin   <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_baud_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_pin  <= w_tx_nxt;
            r_tx_busy <= w_busy_nxt;
            r_bit_idx <= w_bit_nxt;
            if (w_pop) begin
                r_shift <= w_head;
            end
            if (w_cnt_clr || (r_state == S_IDLE)) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
            end
        end
    end

    assign tx_pin    = r_tx_pin;
    assign tx_busy   = r_tx_busy;
    assign fifo_full = w_full;

endmodule
`default_nettype wire
